// File: rtl/trap_seq_ctrl.sv
// Machine-mode trap/mret sequencer: walks the CSR file's single port through the
// mstatus read-modify-write, mepc/mcause saves and target fetch, then redirects the PC.
module trap_seq_ctrl #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret_req,
  output logic        trap_ack,
  output logic        mret_ack,
  output logic [11:0] csr_addr,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    IDLE,
    T_RDST,
    T_WRST,
    T_WEPC,
    T_WCAUSE,
    T_RDVEC,
    T_REDIR,
    M_RDST,
    M_WRST,
    M_RDEPC,
    M_REDIR
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   cause_q;
  logic              trap_take;
  logic              mret_take;

  // Trap has priority; acks are gated by reset so every output is quiet while held.
  assign trap_take = rst && (state == IDLE) && trap_req;
  assign mret_take = rst && (state == IDLE) && !trap_req && mret_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nx;
      if (trap_take) begin
        pc_q    <= trap_pc;
        cause_q <= trap_cause;
      end
    end
  end

  // Next state and per-state CSR port / redirect decode.
  always_comb begin
    state_nx       = state;
    trap_ack       = trap_take;
    mret_ack       = mret_take;
    csr_addr       = 12'h000;
    csr_we         = 1'b0;
    csr_wdata      = '0;
    busy           = (state != IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state)
      IDLE: begin
        if (trap_take)      state_nx = T_RDST;
        else if (mret_take) state_nx = M_RDST;
      end
      T_RDST: begin
        csr_addr = MSTATUS_ADDR;
        state_nx = T_WRST;
      end
      T_WRST: begin
        // MPIE <= MIE, MIE <= 0
        csr_addr  = MSTATUS_ADDR;
        csr_we    = 1'b1;
        csr_wdata = {csr_rdata[31:8], csr_rdata[3], csr_rdata[6:4], 1'b0, csr_rdata[2:0]};
        state_nx  = T_WEPC;
      end
      T_WEPC: begin
        csr_addr  = MEPC_ADDR;
        csr_we    = 1'b1;
        csr_wdata = {pc_q[31:2], 2'b00};
        state_nx  = T_WCAUSE;
      end
      T_WCAUSE: begin
        csr_addr  = MCAUSE_ADDR;
        csr_we    = 1'b1;
        csr_wdata = cause_q;
        state_nx  = T_RDVEC;
      end
      T_RDVEC: begin
        csr_addr = MTVEC_ADDR;
        state_nx = T_REDIR;
      end
      T_REDIR: begin
        // Direct mode only: mtvec mode bits dropped
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_nx       = IDLE;
      end
      M_RDST: begin
        csr_addr = MSTATUS_ADDR;
        state_nx = M_WRST;
      end
      M_WRST: begin
        // MIE <= MPIE, MPIE <= 1
        csr_addr  = MSTATUS_ADDR;
        csr_we    = 1'b1;
        csr_wdata = {csr_rdata[31:8], 1'b1, csr_rdata[6:4], csr_rdata[7], csr_rdata[2:0]};
        state_nx  = M_RDEPC;
      end
      M_RDEPC: begin
        csr_addr = MEPC_ADDR;
        state_nx = M_REDIR;
      end
      M_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
        state_nx       = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Bench for trap_seq_ctrl: CSR file model plus a cycle-stamped scoreboard of
// expected CSR writes and redirects.
module tb_trap_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic        trap_ack;
  logic        mret_ack;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  trap_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret_req       (mret_req),
    .trap_ack       (trap_ack),
    .mret_ack       (mret_ack),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    int          cyc;
    bit          r;
    logic [11:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          t0;
  logic [31:0] mem [4];
  logic [31:0] pred [4];
  logic        set_req = 1'b0;
  logic [1:0]  set_idx = 2'd0;
  logic [31:0] set_val = 32'h0;

  function automatic logic [1:0] cidx(input logic [11:0] a);
    case (a)
      12'h305: return 2'd1;
      12'h341: return 2'd2;
      12'h342: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // CSR file model: read data registered one cycle after the address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (set_req) mem[set_idx] <= set_val;
    else if (csr_we) mem[cidx(csr_addr)] <= csr_wdata;
    csr_rdata <= mem[cidx(csr_addr)];
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (csr_we || redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_event", 96'(exp_q.size()), 96'(1));
        end else begin
          mon_e = exp_q.pop_front();
          check(redirect_valid ? "sb_redirect" : "sb_csr_write",
                96'({32'(cyc), redirect_valid, redirect_valid ? 12'h000 : csr_addr,
                     redirect_valid ? redirect_pc : csr_wdata}),
                96'({32'(mon_e.cyc), mon_e.r, mon_e.a, mon_e.d}));
        end
      end
      check("default_zero",
            96'({csr_we ? 32'h0 : csr_wdata, redirect_valid ? 32'h0 : redirect_pc}), 96'(0));
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_csr(input logic [1:0] idx, input logic [31:0] val);
    set_idx = idx;
    set_val = val;
    set_req = 1'b1;
    pred[idx] = val;
    drive_edge();
    set_req = 1'b0;
  endtask

  task automatic push(input int c, input bit r, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c;
    e.r   = r;
    e.a   = a;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_trap(input int ts, input logic [31:0] pc, input logic [31:0] cause);
    logic [31:0] ms;
    logic [31:0] ns;
    ms = pred[0];
    ns = ms & 32'hFFFF_FF77;
    if (ms[3]) ns = ns | 32'h80;
    push(ts + 2, 1'b0, 12'h300, ns);
    push(ts + 3, 1'b0, 12'h341, pc & 32'hFFFF_FFFC);
    push(ts + 4, 1'b0, 12'h342, cause);
    push(ts + 6, 1'b1, 12'h000, pred[1] & 32'hFFFF_FFFC);
    pred[0] = ns;
    pred[2] = pc & 32'hFFFF_FFFC;
    pred[3] = cause;
  endtask

  task automatic expect_mret(input int ts);
    logic [31:0] ms;
    logic [31:0] ns;
    ms = pred[0];
    ns = (ms & 32'hFFFF_FFF7) | 32'h80;
    if (ms[7]) ns = ns | 32'h8;
    push(ts + 2, 1'b0, 12'h300, ns);
    push(ts + 4, 1'b1, 12'h000, pred[2] & 32'hFFFF_FFFC);
    pred[0] = ns;
  endtask

  // Steps through a busy window of n cycles plus the return-to-idle cycle
  task automatic run_busy(input string tag, input int n, input bit clr_trap,
                          input bit clr_mret, input int mret_at);
    for (int k = 1; k <= n + 1; k++) begin
      drive_edge();
      if (k == 1) begin
        if (clr_trap) trap_req = 1'b0;
        if (clr_mret) mret_req = 1'b0;
      end
      if (k == mret_at) mret_req = 1'b1;
      sample();
      check({tag, "_busy"}, 96'(busy), 96'(k <= n));
      if (k <= n) check({tag, "_no_ack_while_busy"}, 96'({trap_ack, mret_ack}), 96'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    trap_req   = 1'b0;
    mret_req   = 1'b0;
    trap_pc    = 32'h0;
    trap_cause = 32'h0;
    for (int i = 0; i < 4; i++) pred[i] = 32'h0;
    #3;
    rst      = 1'b0;
    trap_req = 1'b1;
    mret_req = 1'b1;
    #1;
    check("reset_outputs", 96'({trap_ack, mret_ack, csr_we, busy, redirect_valid,
                                csr_addr, csr_wdata, redirect_pc}), 96'(0));
    sample();
    check("reset_hold", 96'({trap_ack, mret_ack, csr_we, busy, redirect_valid,
                             csr_addr, csr_wdata, redirect_pc}), 96'(0));
    trap_req = 1'b0;
    mret_req = 1'b0;
    set_csr(2'd0, 32'h0000_0008);
    set_csr(2'd1, 32'h0000_0101);
    set_csr(2'd2, 32'h0);
    set_csr(2'd3, 32'h0);
    rst = 1'b1;

    // Basic trap
    drive_edge();
    trap_pc    = 32'h0000_0046;
    trap_cause = 32'd2;
    trap_req   = 1'b1;
    sample();
    check("t1_ack", 96'({trap_ack, mret_ack}), 96'(2'b10));
    t0 = cyc;
    expect_trap(t0, trap_pc, trap_cause);
    run_busy("t1", 6, 1'b1, 1'b0, 0);
    check("t1_idle_addr", 96'(csr_addr), 96'(0));

    // Basic mret
    set_csr(2'd0, 32'h0000_0080);
    set_csr(2'd2, 32'h0000_0048);
    mret_req = 1'b1;
    sample();
    check("t2_ack", 96'({trap_ack, mret_ack}), 96'(2'b01));
    t0 = cyc;
    expect_mret(t0);
    run_busy("t2", 4, 1'b0, 1'b1, 0);

    // Simultaneous requests: trap first, mret serviced afterwards
    drive_edge();
    trap_pc    = 32'h0000_0100;
    trap_cause = 32'd11;
    trap_req   = 1'b1;
    mret_req   = 1'b1;
    sample();
    check("t3_trap_wins", 96'({trap_ack, mret_ack}), 96'(2'b10));
    t0 = cyc;
    expect_trap(t0, trap_pc, trap_cause);
    run_busy("t3", 6, 1'b1, 1'b0, 0);
    check("t3_mret_ack", 96'({trap_ack, mret_ack}), 96'(2'b01));
    check("t3_mret_ack_cycle", 96'(cyc - t0), 96'(7));
    expect_mret(cyc);
    run_busy("t3m", 4, 1'b0, 1'b1, 0);

    // mret raised mid-trap waits for idle
    drive_edge();
    trap_pc    = 32'h0000_0200;
    trap_cause = 32'd5;
    trap_req   = 1'b1;
    sample();
    check("t4_ack", 96'({trap_ack, mret_ack}), 96'(2'b10));
    t0 = cyc;
    expect_trap(t0, trap_pc, trap_cause);
    run_busy("t4", 6, 1'b1, 1'b0, 3);
    check("t4_mret_ack", 96'({trap_ack, mret_ack}), 96'(2'b01));
    check("t4_mret_ack_cycle", 96'(cyc - t0), 96'(7));
    expect_mret(cyc);
    run_busy("t4m", 4, 1'b0, 1'b1, 0);

    // Reset mid-trap aborts the sequence
    drive_edge();
    trap_pc    = 32'h0000_0300;
    trap_cause = 32'd7;
    trap_req   = 1'b1;
    sample();
    check("t5_ack", 96'({trap_ack, mret_ack}), 96'(2'b10));
    t0 = cyc;
    expect_trap(t0, trap_pc, trap_cause);
    for (int k = 1; k <= 3; k++) begin
      drive_edge();
      if (k == 1) trap_req = 1'b0;
      sample();
    end
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_reset", 96'({trap_ack, mret_ack, csr_we, busy, redirect_valid,
                                 csr_addr, csr_wdata, redirect_pc}), 96'(0));
    exp_q.delete();
    drive_edge();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_edge();
      sample();
      check("t5_quiet_after_reset", 96'({csr_we, redirect_valid, busy}), 96'(0));
    end

    // All-ones mstatus with MIE clear: only MPIE/MIE bits may change
    set_csr(2'd0, 32'hFFFF_FF77);
    trap_pc    = 32'h0000_0404;
    trap_cause = 32'h8000_000B;
    trap_req   = 1'b1;
    sample();
    check("t6_ack", 96'({trap_ack, mret_ack}), 96'(2'b10));
    t0 = cyc;
    expect_trap(t0, trap_pc, trap_cause);
    run_busy("t6", 6, 1'b1, 1'b0, 0);

    repeat (3) sample();
    check("sb_drain", 96'(exp_q.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
